// File: rtl/rob_wb_arbiter_if.sv
// Completion/writeback bundle between the functional units, the ROB and the
// writeback arbiter. The arbiter sits on the slave side.
interface rob_wb_arbiter_if #(
    parameter int NUM_FU    = 6,
    parameter int WB_WIDTH  = 4,
    parameter int DEPTH     = 64,
    parameter int PHYS_REGS = 128
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PRF_W = $clog2(PHYS_REGS);

    logic [NUM_FU-1:0]               fu_valid_i;
    logic [NUM_FU-1:0][IDX_W-1:0]    fu_rob_idx_i;
    logic [NUM_FU-1:0][PRF_W-1:0]    fu_dest_prf_i;
    logic [NUM_FU-1:0]               fu_exception_i;
    logic [NUM_FU-1:0]               fu_mispred_i;
    logic [NUM_FU-1:0]               fu_ready_o;
    logic                            flush_i;
    logic [WB_WIDTH-1:0]             wb_valid_o;
    logic [WB_WIDTH-1:0][IDX_W-1:0]  wb_rob_idx_o;
    logic [WB_WIDTH-1:0][PRF_W-1:0]  wb_dest_prf_o;
    logic [WB_WIDTH-1:0]             wb_exception_o;
    logic [WB_WIDTH-1:0]             wb_mispred_o;

    modport master (
        output fu_valid_i, fu_rob_idx_i, fu_dest_prf_i, fu_exception_i, fu_mispred_i, flush_i,
        input  fu_ready_o, wb_valid_o, wb_rob_idx_o, wb_dest_prf_o, wb_exception_o, wb_mispred_o
    );

    modport slave (
        input  fu_valid_i, fu_rob_idx_i, fu_dest_prf_i, fu_exception_i, fu_mispred_i, flush_i,
        output fu_ready_o, wb_valid_o, wb_rob_idx_o, wb_dest_prf_o, wb_exception_o, wb_mispred_o
    );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Writeback arbiter: one holding buffer per FU, round-robin packing of the
// buffered results onto the ROB writeback slots, flush drops everything.

// One-entry holding buffer for a single FU lane.
module rob_wb_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);
    // Occupancy: a reload wins over the clear caused by this cycle's grant.
    always_ff @(posedge clk) begin
        if (reset || flush) valid <= 1'b0;
        else if (load)      valid <= 1'b1;
        else if (clear)     valid <= 1'b0;
    end

    // Payload only matters while valid, so it is not reset.
    always_ff @(posedge clk) begin
        if (load) dout <= din;
    end
endmodule

module rob_wb_arbiter #(
    parameter int NUM_FU    = 6,
    parameter int WB_WIDTH  = 4,
    parameter int DEPTH     = 64,
    parameter int PHYS_REGS = 128
) (
    input  logic          clk,
    input  logic          reset,
    rob_wb_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PRF_W  = $clog2(PHYS_REGS);
    localparam int PTR_W  = $clog2(NUM_FU);
    localparam int OFF_W  = PTR_W + 1;
    localparam int RANK_W = $clog2(NUM_FU + 1);

    typedef struct packed {
        logic [IDX_W-1:0] rob_idx;
        logic [PRF_W-1:0] dest_prf;
        logic             exception;
        logic             mispred;
    } wb_pay_t;
    localparam int PAY_W = $bits(wb_pay_t);

    wb_pay_t [NUM_FU-1:0]   fu_pay, buf_pay;
    logic    [NUM_FU-1:0]   buf_valid, granted, accept, ready;
    logic    [PTR_W-1:0]    rr_ptr, rr_nxt, last_idx;
    logic    [OFF_W-1:0]    off [NUM_FU];
    logic    [OFF_W-1:0]    best_off;
    logic    [RANK_W-1:0]   rank [NUM_FU];
    wb_pay_t [WB_WIDTH-1:0] slot;
    logic    [WB_WIDTH-1:0] slot_vld;
    logic                   blank;

    logic [WB_WIDTH-1:0]             wb_valid, wb_exc, wb_mis;
    logic [WB_WIDTH-1:0][IDX_W-1:0]  wb_idx;
    logic [WB_WIDTH-1:0][PRF_W-1:0]  wb_prf;

    // Ready depends only on registered state, never on fu_valid_i.
    assign ready          = reset ? '1 : (~buf_valid | granted);
    assign bus.fu_ready_o = ready;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
        assign fu_pay[i] = '{rob_idx:   bus.fu_rob_idx_i[i],
                             dest_prf:  bus.fu_dest_prf_i[i],
                             exception: bus.fu_exception_i[i],
                             mispred:   bus.fu_mispred_i[i]};
        assign accept[i] = bus.fu_valid_i[i] & ready[i] & ~bus.flush_i;

        rob_wb_hold #(.W(PAY_W)) u_hold (
            .clk   (clk),
            .reset (reset),
            .flush (bus.flush_i),
            .load  (accept[i]),
            .clear (granted[i]),
            .din   (fu_pay[i]),
            .valid (buf_valid[i]),
            .dout  (buf_pay[i])
        );
    end

    // Grant: each FU's distance from rr_ptr orders the scan; its rank is the
    // number of valid buffers ahead of it, and rank < WB_WIDTH wins a slot.
    always_comb begin
        granted  = '0;
        best_off = '0;
        last_idx = rr_ptr;
        for (int i = 0; i < NUM_FU; i++) begin
            if (OFF_W'(i) >= {1'b0, rr_ptr}) off[i] = OFF_W'(i) - {1'b0, rr_ptr};
            else                             off[i] = OFF_W'(i) + OFF_W'(NUM_FU) - {1'b0, rr_ptr};
        end
        for (int i = 0; i < NUM_FU; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NUM_FU; j++)
                if (j != i && buf_valid[j] && off[j] < off[i]) rank[i] = rank[i] + RANK_W'(1);
            granted[i] = buf_valid[i] && (rank[i] < RANK_W'(WB_WIDTH));
        end
        // Last granted FU is the one farthest from rr_ptr in scan order.
        for (int i = 0; i < NUM_FU; i++) begin
            if (granted[i] && off[i] >= best_off) begin
                best_off = off[i];
                last_idx = PTR_W'(i);
            end
        end
        rr_nxt = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
    end

    // Round-robin pointer resumes just past the last FU served.
    always_ff @(posedge clk) begin
        if (reset)                              rr_ptr <= '0;
        else if (!bus.flush_i && (|granted))    rr_ptr <= rr_nxt;
    end

    // Slot k carries the granted FU of rank k; unused slots stay zero.
    always_comb begin
        slot     = '0;
        slot_vld = '0;
        blank    = reset | bus.flush_i;
        for (int k = 0; k < WB_WIDTH; k++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (granted[i] && rank[i] == RANK_W'(k)) begin
                    slot_vld[k] = 1'b1;
                    slot[k]     = buf_pay[i];
                end
            end
        end
        for (int k = 0; k < WB_WIDTH; k++) begin
            wb_valid[k] = slot_vld[k] & ~blank;
            wb_idx[k]   = blank ? '0 : slot[k].rob_idx;
            wb_prf[k]   = blank ? '0 : slot[k].dest_prf;
            wb_exc[k]   = slot[k].exception & ~blank;
            wb_mis[k]   = slot[k].mispred & ~blank;
        end
    end

    assign bus.wb_valid_o     = wb_valid;
    assign bus.wb_rob_idx_o   = wb_idx;
    assign bus.wb_dest_prf_o  = wb_prf;
    assign bus.wb_exception_o = wb_exc;
    assign bus.wb_mispred_o   = wb_mis;
endmodule

// File: doc/rob_wb_arbiter.md
Name: rob_wb_arbiter

Overview:
- Collects completions from NUM_FU functional units and arbitrates them onto the ROB's WB_WIDTH writeback ports (ROB wb_valid_i / wb_rob_idx_i / wb_exception_i / wb_mispred_i), plus the destination PRF tag for wakeup.
- Each FU owns a one-entry holding buffer, so a losing FU stalls via ready/valid backpressure instead of dropping results.
- Grants are round-robin.
- A ROB flush clears all buffered results.

Parameters:
- NUM_FU, 6, number of functional-unit completion requesters.
- WB_WIDTH, 4, ROB writeback ports driven per cycle (1..NUM_FU).
- DEPTH, 64, ROB entries; sets ROB index width $clog2(DEPTH).
- PHYS_REGS, 128, physical registers; sets PRF tag width $clog2(PHYS_REGS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fu_valid_i  in  NUM_FU  FU i presents a completed result
- fu_rob_idx_i  in  NUM_FU x $clog2(DEPTH)  ROB index of result
- fu_dest_prf_i  in  NUM_FU x $clog2(PHYS_REGS)  destination PRF tag
- fu_exception_i  in  NUM_FU  result raised exception
- fu_mispred_i  in  NUM_FU  branch mispredicted
- fu_ready_o  out  NUM_FU  holding buffer i can accept this cycle
- flush_i  in  1  ROB flush (ROB flush_o); all in-flight work is younger than the flush point
- wb_valid_o  out  WB_WIDTH  writeback slot k valid
- wb_rob_idx_o  out  WB_WIDTH x $clog2(DEPTH)  ROB index for slot k
- wb_dest_prf_o  out  WB_WIDTH x $clog2(PHYS_REGS)  PRF tag for slot k
- wb_exception_o  out  WB_WIDTH  exception flag for slot k
- wb_mispred_o  out  WB_WIDTH  mispredict flag for slot k

Behaviour:
- State:
  - buf_valid[NUM_FU] plus payload (rob_idx, dest_prf, exception, mispred) per FU.
  - rr_ptr, $clog2(NUM_FU) bits.
- Reset (synchronous): all buf_valid=0, rr_ptr=0. All wb_* outputs 0 and fu_ready_o all-1 in the cycle after reset is sampled and while reset is high. Reset mid-operation discards buffered results.
- Grant (combinational from registered state only):
  - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - Select the first up to WB_WIDTH with buf_valid=1.
  - The j-th selected entry drives slot j; slots beyond the selected count drive valid=0 with payload 0.
  - Slots are packed from slot 0 with no gaps.
- Outputs are driven directly from buffers. Minimum latency: accepted at edge N -> visible on wb_* in cycle N (after edge), i.e. one cycle after fu_valid_i.
- Ready: fu_ready_o[i] = !buf_valid[i] || granted[i]. Full throughput of 1 result per FU per cycle while granted every cycle; no combinational path from fu_valid_i to fu_ready_o.
- Accept: fu_valid_i[i] && fu_ready_o[i] && !flush_i loads buffer i. A granted entry not reloaded clears. fu_valid_i with fu_ready_o=0 is held by the FU, unchanged.
- rr_ptr update:
  - If at least one grant: rr_ptr <= (last granted index + 1) mod NUM_FU.
  - Otherwise rr_ptr holds.
  - Not updated during flush_i.
- Flush:
  - While flush_i=1, wb_valid_o forced 0.
  - On that edge all buf_valid <= 0; inputs that cycle are dropped.
  - fu_ready_o is unaffected.
  - The next cycle behaves like post-reset except rr_ptr is retained.
- Fairness: any buffered entry is granted within ceil(NUM_FU/WB_WIDTH) cycles absent flush.
- Corner cases:
  - Two FUs carrying the same rob_idx is a FU bug; both are forwarded.
  - WB_WIDTH >= NUM_FU means every valid buffer is granted each cycle.
  - Simultaneous grant and accept on the same FU is legal, giving back-to-back results.

Test Plan:
- Reset, then FU0 valid rob_idx=0 prf=10 for one cycle -> next cycle wb_valid_o=4'b0001, wb_rob_idx_o[0]=0, wb_dest_prf_o[0]=10; then wb_valid_o=0.
- All 6 FUs valid for one cycle (rob_idx 1..6), rr_ptr=0 -> cycle 1: slots carry FU0..FU3 (idx 1..4), fu_ready_o[5:4]=0, rr_ptr=4. Cycle 2: slots 0,1 carry FU4, FU5 (idx 5,6), wb_valid_o=4'b0011.
- All FUs valid continuously for 6 cycles -> every FU granted ≥3 times, no FU starves >2 cycles, no result lost or duplicated (scoreboard on rob_idx).
- FU2 valid rob_idx=3 mispred=1 -> slot 0 wb_mispred_o=1, rob_idx=3. Next cycle: assert flush_i with FU1, FU4 buffered -> wb_valid_o=0 that cycle, following cycle buffers empty, wb_valid_o=0.
- Flush with fu_valid_i[0]=1 the same cycle -> result dropped, never appears on wb.
- Reset asserted while 3 buffers are full -> after reset wb_valid_o=0, fu_ready_o=all 1, rr_ptr=0.
